// File: rtl/alu_share_arb.sv
// Round-robin arbiter that shares one RV32I ALU and its control decoder between
// the execute-stage path (port 0) and the auxiliary address/branch unit (port 1).
module alu_share_arb #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,

    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [1:0]       i_req0_alu_op,
    input  logic [3:0]       i_req0_func37,
    input  logic [WIDTH-1:0] i_req0_op1,
    input  logic [WIDTH-1:0] i_req0_op2,
    input  logic [TAG_W-1:0] i_req0_tag,

    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [1:0]       i_req1_alu_op,
    input  logic [3:0]       i_req1_func37,
    input  logic [WIDTH-1:0] i_req1_op1,
    input  logic [WIDTH-1:0] i_req1_op2,
    input  logic [TAG_W-1:0] i_req1_tag,

    output logic [1:0]       o_alu_op,
    output logic [3:0]       o_func37,
    output logic [WIDTH-1:0] o_alu_op1,
    output logic [WIDTH-1:0] o_alu_op2,
    input  logic [WIDTH-1:0] i_alu_result,

    output logic             o_resp0_valid,
    input  logic             i_resp0_ready,
    output logic [WIDTH-1:0] o_resp0_result,
    output logic [TAG_W-1:0] o_resp0_tag,

    output logic             o_resp1_valid,
    input  logic             i_resp1_ready,
    output logic [WIDTH-1:0] o_resp1_result,
    output logic [TAG_W-1:0] o_resp1_tag,

    output logic             o_busy
);

    logic prio;
    logic free0, free1;
    logic elig0, elig1;
    logic gnt0, gnt1;

    // A full buffer counts as free in the cycle its consumer drains it.
    assign free0 = ~o_resp0_valid | i_resp0_ready;
    assign free1 = ~o_resp1_valid | i_resp1_ready;

    // Reset masks eligibility so no grant, ready or ALU drive leaks out while held.
    assign elig0 = i_rst_n & i_req0_valid & free0;
    assign elig1 = i_rst_n & i_req1_valid & free1;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (elig0 && elig1) begin
            gnt0 = ~prio;
            gnt1 = prio;
        end else begin
            gnt0 = elig0;
            gnt1 = elig1;
        end
    end

    assign o_req0_ready = gnt0;
    assign o_req1_ready = gnt1;

    // Idle cycles present ADD 0+0 so the shared ALU sees a quiet, known input.
    always_comb begin
        o_alu_op  = 2'b00;
        o_func37  = 4'b0000;
        o_alu_op1 = '0;
        o_alu_op2 = '0;
        if (gnt0) begin
            o_alu_op  = i_req0_alu_op;
            o_func37  = i_req0_func37;
            o_alu_op1 = i_req0_op1;
            o_alu_op2 = i_req0_op2;
        end else if (gnt1) begin
            o_alu_op  = i_req1_alu_op;
            o_func37  = i_req1_func37;
            o_alu_op1 = i_req1_op1;
            o_alu_op2 = i_req1_op2;
        end
    end

    // Priority passes to the loser of each grant and holds when nothing is granted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
        if (!i_rst_n) begin
            prio <= 1'b0;
        end else if (gnt0) begin
            prio <= 1'b1;
        end else if (gnt1) begin
            prio <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: result and tag registers are reset too, since they are visible outputs with defined reset values.
        if (!i_rst_n) begin
            o_resp0_valid  <= 1'b0;
            o_resp0_result <= '0;
            o_resp0_tag    <= '0;
        end else if (gnt0) begin
            o_resp0_valid  <= 1'b1;
            o_resp0_result <= i_alu_result;
            o_resp0_tag    <= i_req0_tag;
        end else if (o_resp0_valid && i_resp0_ready) begin
            o_resp0_valid  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_resp1_valid  <= 1'b0;
            o_resp1_result <= '0;
            o_resp1_tag    <= '0;
        end else if (gnt1) begin
            o_resp1_valid  <= 1'b1;
            o_resp1_result <= i_alu_result;
            o_resp1_tag    <= i_req1_tag;
        end else if (o_resp1_valid && i_resp1_ready) begin
            o_resp1_valid  <= 1'b0;
        end
    end

    assign o_busy = o_resp0_valid | o_resp1_valid;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios plus randomized traffic
// compared against a transaction-level model of the arbiter and an RV32I ALU model.
module tb_alu_share_arb;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_req0_valid, i_req1_valid;
    logic             o_req0_ready, o_req1_ready;
    logic [1:0]       i_req0_alu_op, i_req1_alu_op;
    logic [3:0]       i_req0_func37, i_req1_func37;
    logic [WIDTH-1:0] i_req0_op1, i_req0_op2, i_req1_op1, i_req1_op2;
    logic [TAG_W-1:0] i_req0_tag, i_req1_tag;
    logic [1:0]       o_alu_op;
    logic [3:0]       o_func37;
    logic [WIDTH-1:0] o_alu_op1, o_alu_op2, i_alu_result;
    logic             o_resp0_valid, o_resp1_valid;
    logic             i_resp0_ready, i_resp1_ready;
    logic [WIDTH-1:0] o_resp0_result, o_resp1_result;
    logic [TAG_W-1:0] o_resp0_tag, o_resp1_tag;
    logic             o_busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: who has priority, and what each response buffer holds.
    bit               m_prio;
    bit   [1:0]       m_valid;
    logic [WIDTH-1:0] m_result [2];
    logic [TAG_W-1:0] m_tag    [2];
    logic [1:0]       cur_g;

    alu_share_arb #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
        .i_req0_alu_op(i_req0_alu_op), .i_req0_func37(i_req0_func37),
        .i_req0_op1(i_req0_op1), .i_req0_op2(i_req0_op2), .i_req0_tag(i_req0_tag),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
        .i_req1_alu_op(i_req1_alu_op), .i_req1_func37(i_req1_func37),
        .i_req1_op1(i_req1_op1), .i_req1_op2(i_req1_op2), .i_req1_tag(i_req1_tag),
        .o_alu_op(o_alu_op), .o_func37(o_func37),
        .o_alu_op1(o_alu_op1), .o_alu_op2(o_alu_op2), .i_alu_result(i_alu_result),
        .o_resp0_valid(o_resp0_valid), .i_resp0_ready(i_resp0_ready),
        .o_resp0_result(o_resp0_result), .o_resp0_tag(o_resp0_tag),
        .o_resp1_valid(o_resp1_valid), .i_resp1_ready(i_resp1_ready),
        .o_resp1_result(o_resp1_result), .o_resp1_tag(o_resp1_tag),
        .o_busy(o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Behavioural stand-in for the shared ALU plus its control decoder.
    function automatic logic [WIDTH-1:0] alu_model(input logic [1:0] op, input logic [3:0] f,
                                                   input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        if (op == 2'b00) return a + b;
        case (f[2:0])
            3'b000:  return f[3] ? a - b : a + b;
            3'b001:  return a << sh;
            3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011:  return (a < b) ? 32'd1 : 32'd0;
            3'b100:  return a ^ b;
            3'b101:  return f[3] ? WIDTH'($signed(a) >>> sh) : a >> sh;
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    assign i_alu_result = alu_model(o_alu_op, o_func37, o_alu_op1, o_alu_op2);

    function automatic logic [1:0] model_grant();
        bit e0, e1;
        if (!i_rst_n) return 2'b00;
        e0 = i_req0_valid && (!m_valid[0] || i_resp0_ready);
        e1 = i_req1_valid && (!m_valid[1] || i_resp1_ready);
        if (e0 && e1) return m_prio ? 2'b10 : 2'b01;
        return {e1, e0};
    endfunction

    task automatic model_advance(input logic [1:0] g);
        if (g[0]) begin
            m_valid[0]  = 1'b1;
            m_result[0] = alu_model(i_req0_alu_op, i_req0_func37, i_req0_op1, i_req0_op2);
            m_tag[0]    = i_req0_tag;
        end else if (m_valid[0] && i_resp0_ready) begin
            m_valid[0] = 1'b0;
        end
        if (g[1]) begin
            m_valid[1]  = 1'b1;
            m_result[1] = alu_model(i_req1_alu_op, i_req1_func37, i_req1_op1, i_req1_op2);
            m_tag[1]    = i_req1_tag;
        end else if (m_valid[1] && i_resp1_ready) begin
            m_valid[1] = 1'b0;
        end
        if (g == 2'b01) m_prio = 1'b1;
        else if (g == 2'b10) m_prio = 1'b0;
    endtask

    task automatic model_reset();
        m_prio = 1'b0;
        m_valid = 2'b00;
        m_result[0] = '0; m_result[1] = '0;
        m_tag[0] = '0;    m_tag[1] = '0;
    endtask

    task automatic set_req0(input logic v, input logic [1:0] op, input logic [3:0] f,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t);
        i_req0_valid = v; i_req0_alu_op = op; i_req0_func37 = f;
        i_req0_op1 = a; i_req0_op2 = b; i_req0_tag = t;
    endtask

    task automatic set_req1(input logic v, input logic [1:0] op, input logic [3:0] f,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t);
        i_req1_valid = v; i_req1_alu_op = op; i_req1_func37 = f;
        i_req1_op1 = a; i_req1_op2 = b; i_req1_tag = t;
    endtask

    // Combinational outputs are sampled at the falling edge, registers 1 ns after the rising edge.
    task automatic to_negedge();
        @(negedge i_clk);
        cur_g = model_grant();
    endtask

    task automatic to_posedge();
        model_advance(cur_g);
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_cycle();
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        i_resp0_ready = 1'b1; i_resp1_ready = 1'b1;
        to_negedge();
        to_posedge();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        model_reset();
        i_resp0_ready = 1'b1; i_resp1_ready = 1'b1;
        set_req0(1'b1, 2'b00, 4'h0, 32'd20, 32'd22, 4'd1);
        set_req1(1'b1, 2'b00, 4'h0, 32'd30, 32'd33, 4'd2);
        to_negedge();
        n_vec++;
        if ({o_req1_ready, o_req0_ready} !== 2'b00) begin
            n_err++; $display("FAIL reset_ready: got %b expected 00", {o_req1_ready, o_req0_ready});
        end
        n_vec++;
        if ({o_alu_op, o_func37, o_alu_op1, o_alu_op2} !== '0) begin
            n_err++; $display("FAIL reset_alu_drive: got op=%h f=%h a=%h b=%h expected all 0",
                              o_alu_op, o_func37, o_alu_op1, o_alu_op2);
        end
        to_posedge();
        n_vec++;
        if ({o_resp1_valid, o_resp0_valid, o_busy} !== 3'b000) begin
            n_err++; $display("FAIL reset_resp_valid: got v1,v0,busy=%b expected 000",
                              {o_resp1_valid, o_resp0_valid, o_busy});
        end
        i_rst_n = 1'b1;
        to_negedge();
        n_vec++;
        if ({o_req1_ready, o_req0_ready} !== 2'b01) begin
            n_err++; $display("FAIL reset_first_grant: got %b expected 01", {o_req1_ready, o_req0_ready});
        end
        to_posedge();
        n_vec++;
        if (o_resp0_valid !== 1'b1 || o_resp0_result !== 32'd42 || o_resp0_tag !== 4'd1) begin
            n_err++; $display("FAIL reset_first_resp: got v=%b r=%0d t=%0d expected v=1 r=42 t=1",
                              o_resp0_valid, o_resp0_result, o_resp0_tag);
        end
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_single();
        set_req1(1'b0, 2'b00, 4'h0, '0, '0, '0);
        set_req0(1'b1, 2'b00, 4'b0000, 32'd5, 32'd7, 4'd3);
        to_negedge();
        n_vec++;
        if (o_req0_ready !== 1'b1 || o_alu_op1 !== 32'd5 || o_alu_op2 !== 32'd7 || o_alu_op !== 2'b00) begin
            n_err++; $display("FAIL single_drive: got rdy=%b a=%0d b=%0d op=%b expected 1/5/7/00",
                              o_req0_ready, o_alu_op1, o_alu_op2, o_alu_op);
        end
        to_posedge();
        n_vec++;
        if (o_resp0_valid !== 1'b1 || o_resp0_result !== 32'd12 || o_resp0_tag !== 4'd3 || o_busy !== 1'b1) begin
            n_err++; $display("FAIL single_resp: got v=%b r=%0d t=%0d busy=%b expected 1/12/3/1",
                              o_resp0_valid, o_resp0_result, o_resp0_tag, o_busy);
        end
        i_req0_valid = 1'b0;
        to_negedge();
        n_vec++;
        if ({o_alu_op, o_func37, o_alu_op1, o_alu_op2} !== '0) begin
            n_err++; $display("FAIL single_idle_drive: got a=%h b=%h expected 0", o_alu_op1, o_alu_op2);
        end
        to_posedge();
        n_vec++;
        if (o_resp0_valid !== 1'b0 || o_resp0_result !== 32'd12 || o_busy !== 1'b0) begin
            n_err++; $display("FAIL single_drain: got v=%b r=%0d busy=%b expected 0/12/0",
                              o_resp0_valid, o_resp0_result, o_busy);
        end
    endtask

    task automatic test_passthrough();
        set_req0(1'b0, 2'b00, 4'h0, '0, '0, '0);
        set_req1(1'b1, 2'b01, 4'b1101, 32'h8000_0000, 32'd4, 4'd9);
        to_negedge();
        n_vec++;
        if (o_req1_ready !== 1'b1 || o_alu_op !== 2'b01 || o_func37 !== 4'b1101) begin
            n_err++; $display("FAIL passthru_drive: got rdy=%b op=%b f=%b expected 1/01/1101",
                              o_req1_ready, o_alu_op, o_func37);
        end
        to_posedge();
        n_vec++;
        if (o_resp1_valid !== 1'b1 || o_resp1_result !== 32'hF800_0000 || o_resp1_tag !== 4'd9) begin
            n_err++; $display("FAIL passthru_resp: got v=%b r=%h t=%0d expected 1/f8000000/9",
                              o_resp1_valid, o_resp1_result, o_resp1_tag);
        end
        idle_cycle();
    endtask

    task automatic test_contention();
        i_resp0_ready = 1'b1; i_resp1_ready = 1'b1;
        set_req0(1'b1, 2'b10, 4'b1000, 32'd10, 32'd3, 4'd1);
        set_req1(1'b1, 2'b00, 4'b0000, 32'd1, 32'd1, 4'd2);
        for (int i = 0; i < 4; i++) begin
            to_negedge();
            n_vec++;
            if (o_req0_ready !== (i % 2 == 0) || o_req1_ready !== (i % 2 == 1)) begin
                n_err++; $display("FAIL contention_grant[%0d]: got r1,r0=%b%b expected port %0d",
                                  i, o_req1_ready, o_req0_ready, i % 2);
            end
            to_posedge();
            n_vec++;
            if (i % 2 == 0) begin
                if (o_resp0_valid !== 1'b1 || o_resp0_result !== 32'd7 || o_resp0_tag !== 4'd1) begin
                    n_err++; $display("FAIL contention_resp0[%0d]: got v=%b r=%0d expected 1/7", i,
                                      o_resp0_valid, o_resp0_result);
                end
            end else begin
                if (o_resp1_valid !== 1'b1 || o_resp1_result !== 32'd2 || o_resp1_tag !== 4'd2) begin
                    n_err++; $display("FAIL contention_resp1[%0d]: got v=%b r=%0d expected 1/2", i,
                                      o_resp1_valid, o_resp1_result);
                end
            end
        end
        idle_cycle();
    endtask

    task automatic test_backpressure();
        i_resp0_ready = 1'b1; i_resp1_ready = 1'b0;
        set_req0(1'b0, 2'b00, 4'h0, '0, '0, '0);
        set_req1(1'b1, 2'b11, 4'b0110, 32'hF0, 32'h0F, 4'd5);
        to_negedge();
        to_posedge();
        n_vec++;
        if (o_resp1_valid !== 1'b1 || o_resp1_result !== 32'hFF) begin
            n_err++; $display("FAIL bp_fill: got v=%b r=%h expected 1/ff", o_resp1_valid, o_resp1_result);
        end
        set_req1(1'b1, 2'b00, 4'b0000, 32'h1000, 32'h234, 4'd6);
        for (int i = 0; i < 3; i++) begin
            set_req0(1'b1, 2'b00, 4'b0000, 32'(i), 32'd100, 4'(i + 8));
            to_negedge();
            n_vec++;
            if (o_req0_ready !== 1'b1 || o_req1_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_grant[%0d]: got r1,r0=%b%b expected 01", i, o_req1_ready, o_req0_ready);
            end
            to_posedge();
            n_vec++;
            if (o_resp1_valid !== 1'b1 || o_resp1_result !== 32'hFF || o_resp1_tag !== 4'd5 ||
                o_resp0_result !== 32'(100 + i)) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v1=%b r1=%h t1=%0d r0=%0d expected 1/ff/5/%0d",
                                  i, o_resp1_valid, o_resp1_result, o_resp1_tag, o_resp0_result, 100 + i);
            end
        end
        i_resp1_ready = 1'b1;
        to_negedge();
        n_vec++;
        if (o_req1_ready !== 1'b1 || o_req0_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_refill_grant: got r1,r0=%b%b expected 10", o_req1_ready, o_req0_ready);
        end
        to_posedge();
        n_vec++;
        if (o_resp1_valid !== 1'b1 || o_resp1_result !== 32'h1234 || o_resp1_tag !== 4'd6) begin
            n_err++; $display("FAIL bp_refill_resp: got v=%b r=%h t=%0d expected 1/1234/6",
                              o_resp1_valid, o_resp1_result, o_resp1_tag);
        end
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_random();
        logic [1:0]       e_op;
        logic [3:0]       e_f;
        logic [WIDTH-1:0] e_a, e_b;
        for (int i = 0; i < 400; i++) begin
            i_resp0_ready = ($urandom_range(99) < 60);
            i_resp1_ready = ($urandom_range(99) < 60);
            set_req0(($urandom_range(99) < 70), 2'($urandom), 4'($urandom), $urandom,
                     32'($urandom_range(40)), 4'($urandom));
            set_req1(($urandom_range(99) < 70), 2'($urandom), 4'($urandom), $urandom,
                     32'($urandom_range(40)), 4'($urandom));
            to_negedge();
            {e_op, e_f, e_a, e_b} = '0;
            if (cur_g[0])      {e_op, e_f, e_a, e_b} = {i_req0_alu_op, i_req0_func37, i_req0_op1, i_req0_op2};
            else if (cur_g[1]) {e_op, e_f, e_a, e_b} = {i_req1_alu_op, i_req1_func37, i_req1_op1, i_req1_op2};
            n_vec++;
            if ({o_req1_ready, o_req0_ready} !== cur_g) begin
                n_err++; $display("FAIL rand_grant[%0d]: got %b expected %b", i, {o_req1_ready, o_req0_ready}, cur_g);
            end
            n_vec++;
            if ({o_alu_op, o_func37, o_alu_op1, o_alu_op2} !== {e_op, e_f, e_a, e_b}) begin
                n_err++; $display("FAIL rand_alu_drive[%0d]: got %b/%b/%h/%h expected %b/%b/%h/%h", i,
                                  o_alu_op, o_func37, o_alu_op1, o_alu_op2, e_op, e_f, e_a, e_b);
            end
            to_posedge();
            n_vec++;
            if (o_resp0_valid !== m_valid[0] || o_resp0_result !== m_result[0] || o_resp0_tag !== m_tag[0]) begin
                n_err++; $display("FAIL rand_resp0[%0d]: got %b/%h/%h expected %b/%h/%h", i,
                                  o_resp0_valid, o_resp0_result, o_resp0_tag, m_valid[0], m_result[0], m_tag[0]);
            end
            n_vec++;
            if (o_resp1_valid !== m_valid[1] || o_resp1_result !== m_result[1] || o_resp1_tag !== m_tag[1]) begin
                n_err++; $display("FAIL rand_resp1[%0d]: got %b/%h/%h expected %b/%h/%h", i,
                                  o_resp1_valid, o_resp1_result, o_resp1_tag, m_valid[1], m_result[1], m_tag[1]);
            end
            n_vec++;
            if (o_busy !== (m_valid[0] | m_valid[1])) begin
                n_err++; $display("FAIL rand_busy[%0d]: got %b expected %b", i, o_busy, m_valid[0] | m_valid[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        // Leave non-zero results behind so the reset clear is visible.
        i_resp0_ready = 1'b0; i_resp1_ready = 1'b0;
        set_req0(1'b1, 2'b00, 4'h0, 32'd77, 32'd1, 4'd7);
        set_req1(1'b1, 2'b00, 4'h0, 32'd55, 32'd1, 4'd5);
        to_negedge(); to_posedge();
        to_negedge(); to_posedge();
        i_resp0_ready = 1'b1; i_resp1_ready = 1'b1;
        to_negedge();
        #1 i_rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if ({o_req1_ready, o_req0_ready, o_resp1_valid, o_resp0_valid, o_busy} !== 5'b0) begin
            n_err++; $display("FAIL midreset_ctrl: got r1,r0,v1,v0,busy=%b expected 00000",
                              {o_req1_ready, o_req0_ready, o_resp1_valid, o_resp0_valid, o_busy});
        end
        n_vec++;
        if ({o_resp0_result, o_resp0_tag, o_resp1_result, o_resp1_tag} !== '0 ||
            {o_alu_op, o_func37, o_alu_op1, o_alu_op2} !== '0) begin
            n_err++; $display("FAIL midreset_data: got r0=%h t0=%h r1=%h t1=%h a=%h expected 0",
                              o_resp0_result, o_resp0_tag, o_resp1_result, o_resp1_tag, o_alu_op1);
        end
        cur_g = 2'b00;
        to_posedge();
        i_rst_n = 1'b1;
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        to_negedge();
        to_posedge();
        n_vec++;
        if ({o_resp1_valid, o_resp0_valid} !== 2'b00 || o_resp0_result !== '0) begin
            n_err++; $display("FAIL midreset_no_resp: got v1,v0=%b r0=%h expected 00/0",
                              {o_resp1_valid, o_resp0_valid}, o_resp0_result);
        end
        i_req0_valid = 1'b1; i_req1_valid = 1'b1;
        to_negedge();
        n_vec++;
        if ({o_req1_ready, o_req0_ready} !== 2'b01) begin
            n_err++; $display("FAIL midreset_first_grant: got %b expected 01", {o_req1_ready, o_req0_ready});
        end
        to_posedge();
        n_vec++;
        if (o_resp0_valid !== 1'b1 || o_resp0_result !== 32'd78 || o_resp0_tag !== 4'd7) begin
            n_err++; $display("FAIL midreset_resp: got v=%b r=%0d t=%0d expected 1/78/7",
                              o_resp0_valid, o_resp0_result, o_resp0_tag);
        end
        idle_cycle();
    endtask

    initial begin
        cur_g = 2'b00;
        test_reset();
        test_single();
        test_passthrough();
        test_contention();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
